mips_instr_encoder: RTL and testbench
=====================================

// Module: mips_instr_encoder
// PURPOSE
//  Encoder counterpart of the single-cycle controller's opcode/func decode: takes symbolic instructions
//  (op select + register/immediate fields) over a valid/ready handshake, builds the 32-bit MIPS word
//  and writes it sequentially into instruction memory. Used by the testbench/boot loader to fill imem.
// PARAMETERS
//  ADDR_W     8   imem word-address width
//  DEPTH      256 words writable before FULL (DEPTH <= 2**ADDR_W)
//  BASE_ADDR  0   first word address written after reset/clear
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   synchronous, active-low reset
//  clear       in   1   restart at BASE_ADDR, leave FULL, clear err
//  in_valid    in   1   instruction fields valid
//  in_ready    out  1   encoder can accept
//  in_op       in   5   op select: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 MULT,7 DIV,8 JR,9 MFLO,10 MFHI,
//                       11 LW,12 SW,13 SLTI,14 LUI,15 J,16 JAL,17 ADDI,18 BEQ,19 BNE; 20-31 illegal
//  in_rs/in_rt/in_rd in 5 each  register fields
//  in_imm      in   16  immediate / branch offset
//  in_target   in   26  jump target (word index)
//  imem_we     out  1   instruction-memory write strobe
//  imem_addr   out  ADDR_W  write address
//  imem_wdata  out  32  encoded word
//  count       out  ADDR_W+1 words written since reset/clear
//  full        out  1   DEPTH words written
//  err         out  1   sticky: illegal op seen
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE, in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0,
//   count=0, full=0, err=0. Reset mid-WRITE aborts the write (no strobe).
//  FSM IDLE -> WRITE on in_valid&&in_ready with legal op; word registered at that edge.
//   WRITE: imem_we=1 for exactly one cycle, in_ready=0; next edge imem_addr++, count++;
//   -> FULL if count reaches DEPTH, else IDLE. Throughput 1 word / 2 cycles, latency 1 cycle accept->we.
//   FULL: in_ready=0, full=1; only clear or reset leave it.
//  Illegal op accepted in IDLE: dropped, err<=1, stays IDLE, address unchanged.
//  clear in any state: next state IDLE, addr=BASE_ADDR, count=0, full=0, err=0; pending write discarded;
//   clear has priority over a simultaneous handshake (input not accepted).
//  Layout: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6]=0 func[5:0]; I: imm[15:0]; J: target[25:0].
//  R (op=0) func: ADD 32, SUB 34, AND 36, OR 37, XOR 38, SLT 42, MULT 24, DIV 26, JR 8, MFLO 18, MFHI 16.
//   MULT/DIV rd=0; JR rt=rd=0; MFLO/MFHI rs=rt=0. Unused fields forced 0 regardless of inputs.
//  I/J opcode: LW 35, SW 43, SLTI 10, LUI 15 (rs=0), J 2, JAL 3, ADDI 8, BEQ 4, BNE 5.
//  imem_addr wraps modulo 2**ADDR_W only if DEPTH=2**ADDR_W; FULL prevents any write past DEPTH.
// CONFIGURATION
//  BRANCH_ABS_EN defined: for BEQ/BNE in_imm is an absolute word address; encoded
//   offset = in_imm - (imem_addr+1), 16-bit two's complement; if the true difference lies outside
//   [-32768,32767] the word is dropped and err<=1. Undefined: in_imm is copied verbatim as the offset.
// STRUCTURE
//  mips_isa_pkg: localparams for opcodes, func codes, op-select enum, field bit positions.
//  Sub-module mips_instr_fmt: combinational op/fields -> {legal, word32}; this block holds FSM,
//   address/count registers and the optional branch-offset subtractor.
// TESTING
//  Reset, then ADD rs=1 rt=2 rd=3 -> 1 cycle later imem_we=1, addr 0, wdata 32'h00221820.
//  LW rs=4 rt=5 imm=16'h0010 then J target=26'h0000040 -> wdata 32'h8C850010 @0, 32'h08000040 @1, count=2.
//  in_op=25 -> no imem_we, err=1, address unchanged; next legal instr written at same address.
//  DEPTH=4: five back-to-back instrs -> 4 writes, full=1, in_ready=0; clear -> addr=BASE_ADDR, full=0.
//  BRANCH_ABS_EN: BEQ rs=1 rt=2 at addr 10, in_imm=5 -> wdata 32'h1022FFFA; without macro in_imm=5 -> 32'h10220005.
//  rst_n=0 during WRITE cycle -> imem_we low from that edge, all outputs at reset values.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS-I subset encoding constants: op-select enum, opcodes, func codes, field positions.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_XOR  = 5'd4,  OP_SLT  = 5'd5,  OP_MULT = 5'd6,  OP_DIV  = 5'd7,
    OP_JR   = 5'd8,  OP_MFLO = 5'd9,  OP_MFHI = 5'd10, OP_LW   = 5'd11,
    OP_SW   = 5'd12, OP_SLTI = 5'd13, OP_LUI  = 5'd14, OP_J    = 5'd15,
    OP_JAL  = 5'd16, OP_ADDI = 5'd17, OP_BEQ  = 5'd18, OP_BNE  = 5'd19
  } op_sel_e;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_LW    = 6'd35;
  localparam logic [5:0] OPC_SW    = 6'd43;
  localparam logic [5:0] OPC_SLTI  = 6'd10;
  localparam logic [5:0] OPC_LUI   = 6'd15;
  localparam logic [5:0] OPC_J     = 6'd2;
  localparam logic [5:0] OPC_JAL   = 6'd3;
  localparam logic [5:0] OPC_ADDI  = 6'd8;
  localparam logic [5:0] OPC_BEQ   = 6'd4;
  localparam logic [5:0] OPC_BNE   = 6'd5;

  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_MULT = 6'd24;
  localparam logic [5:0] FN_DIV  = 6'd26;
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_MFLO = 6'd18;
  localparam logic [5:0] FN_MFHI = 6'd16;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;

  // shamt is never used by this subset, so bits [10:6] stay zero
  function automatic logic [31:0] r_word(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd);
    return {OPC_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_word(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(logic [5:0] opc, logic [25:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/mips_instr_fmt.sv
// Combinational formatter: op select and operand fields -> legal flag and 32-bit MIPS word.
module mips_instr_fmt
  import mips_isa_pkg::*;
(
  input  logic [4:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic        o_legal,
  output logic [31:0] o_word
);

  always_comb begin
    o_legal = 1'b1;
    o_word  = 32'd0;
    case (i_op)
      OP_ADD:  o_word = r_word(FN_ADD,  i_rs, i_rt, i_rd);
      OP_SUB:  o_word = r_word(FN_SUB,  i_rs, i_rt, i_rd);
      OP_AND:  o_word = r_word(FN_AND,  i_rs, i_rt, i_rd);
      OP_OR:   o_word = r_word(FN_OR,   i_rs, i_rt, i_rd);
      OP_XOR:  o_word = r_word(FN_XOR,  i_rs, i_rt, i_rd);
      OP_SLT:  o_word = r_word(FN_SLT,  i_rs, i_rt, i_rd);
      OP_MULT: o_word = r_word(FN_MULT, i_rs, i_rt, 5'd0);
      OP_DIV:  o_word = r_word(FN_DIV,  i_rs, i_rt, 5'd0);
      OP_JR:   o_word = r_word(FN_JR,   i_rs, 5'd0, 5'd0);
      OP_MFLO: o_word = r_word(FN_MFLO, 5'd0, 5'd0, i_rd);
      OP_MFHI: o_word = r_word(FN_MFHI, 5'd0, 5'd0, i_rd);
      OP_LW:   o_word = i_word(OPC_LW,   i_rs, i_rt, i_imm);
      OP_SW:   o_word = i_word(OPC_SW,   i_rs, i_rt, i_imm);
      OP_SLTI: o_word = i_word(OPC_SLTI, i_rs, i_rt, i_imm);
      OP_LUI:  o_word = i_word(OPC_LUI,  5'd0, i_rt, i_imm);
      OP_J:    o_word = j_word(OPC_J,   i_target);
      OP_JAL:  o_word = j_word(OPC_JAL, i_target);
      OP_ADDI: o_word = i_word(OPC_ADDI, i_rs, i_rt, i_imm);
      OP_BEQ:  o_word = i_word(OPC_BEQ,  i_rs, i_rt, i_imm);
      OP_BNE:  o_word = i_word(OPC_BNE,  i_rs, i_rt, i_imm);
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic instructions and writes them sequentially into instruction memory.
// Optional macro BRANCH_ABS_EN: BEQ/BNE in_imm is an absolute word address converted to an offset.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_e;

  state_e              r_state;
  logic                r_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [ADDR_W:0]     r_count;
  logic                r_full;
  logic                r_err;

  logic [15:0]         w_imm;
  logic                w_range_ok;
  logic                w_legal;
  logic [31:0]         w_word;
  logic [ADDR_W:0]     w_count_nxt;

`ifdef BRANCH_ABS_EN
  // 18-bit signed difference so an out-of-range offset is detectable before truncation
  logic signed [17:0] w_diff;
  logic               w_is_branch;
  assign w_is_branch = (in_op == OP_BEQ) || (in_op == OP_BNE);
  assign w_diff      = $signed({2'b00, in_imm}) - $signed({{(18-ADDR_W){1'b0}}, r_addr}) - 18'sd1;
  assign w_range_ok  = !w_is_branch || ((w_diff >= -18'sd32768) && (w_diff <= 18'sd32767));
  assign w_imm       = w_is_branch ? w_diff[15:0] : in_imm;
`else
  assign w_range_ok  = 1'b1;
  assign w_imm       = in_imm;
`endif

  mips_instr_fmt u_fmt (
    .i_op     (in_op),
    .i_rs     (in_rs),
    .i_rt     (in_rt),
    .i_rd     (in_rd),
    .i_imm    (w_imm),
    .i_target (in_target),
    .o_legal  (w_legal),
    .o_word   (w_word)
  );

  assign w_count_nxt = r_count + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= BASE;
      r_wdata <= 32'd0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= BASE;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_ready) begin
            if (w_legal && w_range_ok) begin
              r_wdata <= w_word;
              r_we    <= 1'b1;
              r_ready <= 1'b0;
              r_state <= S_WRITE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_we    <= 1'b0;
          r_addr  <= r_addr + 1'b1;
          r_count <= w_count_nxt;
          if (w_count_nxt == DEPTH_CNT) begin
            r_full  <= 1'b1;
            r_state <= S_FULL;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_FULL: begin
          r_ready <= 1'b0;
          r_full  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign full       = r_full;
  assign err        = r_err;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed + randomized bench for mips_instr_encoder with a table-driven encoding model.
module tb_mips_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int BASE   = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_addr, m_count;
  bit m_full, m_err;

  // encoding tables: R-type funcs for ops 0..10, opcodes for ops 11..19
  int unsigned fn_tbl [11] = '{32, 34, 36, 37, 38, 42, 24, 26, 8, 18, 16};
  int unsigned opc_tbl[9]  = '{35, 43, 10, 15, 2, 3, 8, 4, 5};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_encode(input int op, input int rs, input int rt, input int rd,
                              input int imm, input int tgt, input int addr,
                              output logic [31:0] w, output bit legal);
    int unsigned opc, urs, urt, urd, uimm;
    legal = 1'b1;
    w = 32'd0;
    if (op <= 10) begin
      urs = (op == 9 || op == 10) ? 0 : rs;
      urt = (op >= 8) ? 0 : rt;
      urd = (op == 6 || op == 7 || op == 8) ? 0 : rd;
      w = urs * 2097152 + urt * 65536 + urd * 2048 + fn_tbl[op];
    end else if (op <= 19) begin
      opc = opc_tbl[op - 11];
      if (op == 15 || op == 16) begin
        w = opc * 67108864 + tgt;
      end else begin
        urs  = (op == 14) ? 0 : rs;
        uimm = imm;
`ifdef BRANCH_ABS_EN
        if (op == 18 || op == 19) begin
          int diff;
          diff = imm - (addr + 1);
          if (diff < -32768 || diff > 32767) legal = 1'b0;
          uimm = diff & 16'hFFFF;
        end
`endif
        w = opc * 67108864 + urs * 2097152 + rt * 65536 + uimm;
      end
    end else begin
      legal = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_addr = BASE; m_count = 0; m_full = 0; m_err = 0;
  endtask

  // Drives one instruction and checks the resulting write (or rejection) against the model.
  task automatic do_instr(input int op, input int rs, input int rt, input int rd,
                          input int imm, input int tgt);
    logic [31:0] ew;
    bit          legal;
    @(negedge clk);
    chk("ready_before", in_ready, !m_full);
    in_op = op[4:0]; in_rs = rs[4:0]; in_rt = rt[4:0]; in_rd = rd[4:0];
    in_imm = imm[15:0]; in_target = tgt[25:0];
    in_valid = 1'b1;
    model_encode(op, rs, rt, rd, imm, tgt, m_addr, ew, legal);
    @(negedge clk);
    in_valid = 1'b0;
    if (m_full) begin
      chk("full_no_we", imem_we, 0);
      chk("full_flag", full, 1);
    end else if (legal) begin
      chk("we", imem_we, 1);
      chk("addr", imem_addr, m_addr);
      chk("wdata", imem_wdata, ew);
      chk("ready_busy", in_ready, 0);
      @(negedge clk);
      m_addr = (m_addr + 1) % (1 << ADDR_W);
      m_count++;
      if (m_count == DEPTH) m_full = 1;
      chk("we_one_cycle", imem_we, 0);
      chk("count", count, m_count);
      chk("full", full, m_full);
      chk("addr_next", imem_addr, m_addr);
    end else begin
      m_err = 1;
      chk("illegal_no_we", imem_we, 0);
      chk("err", err, 1);
      chk("addr_kept", imem_addr, m_addr);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    in_op = 5'd0;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    model_reset();
    chk("clr_we", imem_we, 0);
    chk("clr_addr", imem_addr, BASE);
    chk("clr_count", count, 0);
    chk("clr_full", full, 0);
    chk("clr_err", err, 0);
    chk("clr_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);

    // ADD r3 = r1 + r2
    do_instr(0, 1, 2, 3, 16'h1234, 0);
    chk("add_word", imem_wdata, 32'h00221820);

    do_clear();
    do_instr(11, 4, 5, 0, 16'h0010, 0);
    chk("lw_word", imem_wdata, 32'h8C850010);
    do_instr(15, 7, 7, 7, 16'hFFFF, 26'h0000040);
    chk("j_word", imem_wdata, 32'h08000040);
    chk("j_count", count, 2);

    // illegal op, then legal op lands at the same address
    do_instr(25, 1, 2, 3, 5, 0);
    do_instr(18, 1, 2, 0, 5, 0);
`ifndef BRANCH_ABS_EN
    chk("beq_word", imem_wdata, 32'h10220005);
`endif
    chk("beq_addr", imem_addr, 3);

    // fill to DEPTH and push one past it
    do_clear();
    for (int i = 0; i < 5; i++) do_instr(i, i + 1, i + 2, i + 3, i, i);
    chk("full_ready", in_ready, 0);
    chk("full_count", count, DEPTH);
    do_clear();

    // reset asserted while the write strobe is high
    @(negedge clk);
    in_op = 5'd1; in_rs = 5'd9; in_rt = 5'd10; in_rd = 5'd11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_we", imem_we, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("mid_rst_we", imem_we, 0);
    chk("mid_rst_wdata", imem_wdata, 0);
    chk("mid_rst_addr", imem_addr, BASE);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    chk("mid_rst_hold", imem_we, 0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      op = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 31) : $urandom_range(0, 19);
      do_instr(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 65535), $urandom_range(0, 67108863));
      chk("rnd_err", err, m_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
